// File: rtl/avatar_pkg.sv
// Shared types for the avatar motion controller.
// Action codes match the game-controller output encoding.
package avatar_pkg;

  typedef enum logic [1:0] {
    ACT_STAND = 2'b00,
    ACT_JUMP  = 2'b01,
    ACT_DIVE  = 2'b10,
    ACT_RUN   = 2'b11
  } action_t;

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10,
    DIVE   = 2'b11
  } motion_state_t;

  localparam logic [1:0] POSE_STAND = 2'b00;
  localparam logic [1:0] POSE_AIR   = 2'b01;
  localparam logic [1:0] POSE_DIVE  = 2'b10;
  localparam logic [1:0] POSE_RUN   = 2'b11;

endpackage

// File: rtl/avatar_motion.sv
// Avatar motion controller: run, jump arc, dive and landing,
// advanced one step per frame tick.
module avatar_motion
  import avatar_pkg::*;
#(
  parameter int JUMP_PEAK = 7,
  parameter int RUN_STEP  = 2,
  parameter int DIVE_STEP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] action,
  input  logic       frame_tick,
  output logic [7:0] xpos,
  output logic [3:0] height,
  output logic [1:0] pose,
  output logic       airborne,
  output logic       land,
  output logic [7:0] jump_count
);

  localparam logic [7:0] RS   = 8'(RUN_STEP);
  localparam logic [4:0] DS   = 5'(DIVE_STEP);
  localparam logic [3:0] PEAK = 4'(JUMP_PEAK);

  motion_state_t state, state_d;
  action_t       act;
  logic [7:0]    vx, vx_d;
  logic          run_flag, run_d;
  logic [7:0]    xpos_d, jcnt_d;
  logic [3:0]    height_d, dived;
  logic [1:0]    pose_d;
  logic          land_d, diving, landing;

  assign act      = action_t'(action);
  assign airborne = (state != GROUND);
  assign dived    = ({1'b0, height} > DS)
                  ? 4'({1'b0, height} - DS) : 4'd0;

  always_comb begin
    state_d  = state;
    xpos_d   = xpos;
    height_d = height;
    pose_d   = pose;
    jcnt_d   = jump_count;
    vx_d     = vx;
    run_d    = run_flag;
    land_d   = 1'b0;
    diving   = 1'b0;
    landing  = 1'b0;
    if (frame_tick) begin
      unique case (state)
        GROUND: begin
          unique case (act)
            ACT_JUMP: begin
              // A one-high peak is reached at launch.
              state_d  = (PEAK <= 4'd1) ? FALL : RISE;
              height_d = 4'd1;
              vx_d     = run_flag ? RS : 8'd0;
              jcnt_d   = (jump_count == 8'hFF)
                       ? jump_count : jump_count + 8'd1;
              pose_d   = POSE_AIR;
            end
            ACT_RUN: begin
              xpos_d = xpos + RS;
              run_d  = 1'b1;
              pose_d = POSE_RUN;
            end
            ACT_STAND: begin
              run_d  = 1'b0;
              pose_d = POSE_STAND;
            end
            ACT_DIVE: begin
              run_d  = 1'b0;
              pose_d = POSE_DIVE;
            end
          endcase
        end
        RISE, FALL: begin
          if (act == ACT_DIVE) begin
            diving = 1'b1;
          end else begin
            xpos_d = xpos + vx;
            if (state == RISE) begin
              height_d = height + 4'd1;
              if (height_d == PEAK) state_d = FALL;
            end else begin
              height_d = height - 4'd1;
              if (height_d == 4'd0) landing = 1'b1;
            end
          end
        end
        DIVE: diving = 1'b1;
      endcase
    end
    if (diving) begin
      state_d  = DIVE;
      height_d = dived;
      pose_d   = POSE_DIVE;
      if (dived == 4'd0) landing = 1'b1;
    end
    if (landing) begin
      state_d  = GROUND;
      height_d = 4'd0;
      land_d   = 1'b1;
      vx_d     = 8'd0;
      run_d    = 1'b0;
      pose_d   = POSE_STAND;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= GROUND;
      xpos       <= 8'd0;
      height     <= 4'd0;
      pose       <= POSE_STAND;
      land       <= 1'b0;
      jump_count <= 8'd0;
      vx         <= 8'd0;
      run_flag   <= 1'b0;
    end else begin
      state      <= state_d;
      xpos       <= xpos_d;
      height     <= height_d;
      pose       <= pose_d;
      land       <= land_d;
      jump_count <= jcnt_d;
      vx         <= vx_d;
      run_flag   <= run_d;
    end
  end

endmodule

// File: tb/tb_avatar_motion.sv
// Bench for avatar_motion: directed scenarios plus random
// frames, checked against a trajectory-level reference model.
module tb_avatar_motion;

  localparam int JP = 7;
  localparam int RS = 2;
  localparam int DS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [1:0] action = 2'b00;
  logic [7:0] xpos, jump_count;
  logic [3:0] height;
  logic [1:0] pose;
  logic       airborne, land;

  int tests = 0;
  int fails = 0;
  int lands = 0;
  int peak  = 0;

  // reference model: position, vertical direction, mode flags
  int mx, mh, mjc, mvx, mpose;
  bit mrun, mland, mair, mdive, mup;

  avatar_motion #(
    .JUMP_PEAK(JP),
    .RUN_STEP (RS),
    .DIVE_STEP(DS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .action    (action),
    .frame_tick(frame_tick),
    .xpos      (xpos),
    .height    (height),
    .pose      (pose),
    .airborne  (airborne),
    .land      (land),
    .jump_count(jump_count)
  );

  always #5 clk = ~clk;

  task automatic touch_down();
    mair  = 0;
    mdive = 0;
    mland = 1;
    mh    = 0;
    mvx   = 0;
    mrun  = 0;
    mpose = 0;
  endtask

  task automatic model_step(bit r, bit t, int a);
    mland = 0;
    if (r) begin
      mx = 0; mh = 0; mjc = 0; mvx = 0; mpose = 0;
      mrun = 0; mair = 0; mdive = 0; mup = 0;
    end else if (t) begin
      if (!mair) begin
        case (a)
          1: begin
            mair = 1; mdive = 0; mup = (JP > 1);
            mh = 1; mvx = mrun ? RS : 0;
            mjc = (mjc < 255) ? mjc + 1 : 255;
            mpose = 1;
          end
          3: begin mx = (mx + RS) % 256; mrun = 1; mpose = 3; end
          2: begin mrun = 0; mpose = 2; end
          default: begin mrun = 0; mpose = 0; end
        endcase
      end else if (mdive || a == 2) begin
        mdive = 1;
        mpose = 2;
        mh = (mh > DS) ? mh - DS : 0;
        if (mh == 0) touch_down();
      end else begin
        mx = (mx + mvx) % 256;
        mh = mup ? mh + 1 : mh - 1;
        if (mh == JP) mup = 0;
        if (mh == 0) touch_down();
      end
    end
  endtask

  task automatic check(string tag);
    tests++;
    assert (xpos === 8'(mx)) else begin
      fails++; $error("FAIL %s xpos got %0d exp %0d", tag, xpos, mx);
    end
    tests++;
    assert (height === 4'(mh)) else begin
      fails++; $error("FAIL %s height got %0d exp %0d", tag, height, mh);
    end
    tests++;
    assert (pose === 2'(mpose)) else begin
      fails++; $error("FAIL %s pose got %0d exp %0d", tag, pose, mpose);
    end
    tests++;
    assert (airborne === mair) else begin
      fails++; $error("FAIL %s airborne got %0b exp %0b", tag, airborne, mair);
    end
    tests++;
    assert (land === mland) else begin
      fails++; $error("FAIL %s land got %0b exp %0b", tag, land, mland);
    end
    tests++;
    assert (jump_count === 8'(mjc)) else begin
      fails++; $error("FAIL %s jump_count got %0d exp %0d", tag, jump_count, mjc);
    end
  endtask

  task automatic expect_eq(string tag, int got, int exp);
    tests++;
    assert (got === exp) else begin
      fails++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic cycle(bit r, bit t, int a, string tag);
    reset      = r;
    frame_tick = t;
    action     = 2'(a);
    @(negedge clk);
    model_step(r, t, a);
    if (land) lands++;
    if (int'(height) > peak) peak = int'(height);
    check(tag);
  endtask

  initial begin
    int hs [6];
    hs = '{1, 2, 3, 4, 2, 0};
    cycle(1, 0, 0, "reset");
    cycle(1, 1, 3, "reset_tick");

    for (int i = 0; i < 3; i++) cycle(0, 1, 3, "run");
    expect_eq("run_xpos", int'(xpos), 6);
    expect_eq("run_pose", int'(pose), 3);
    expect_eq("run_height", int'(height), 0);

    lands = 0; peak = 0;
    cycle(0, 1, 1, "runjump");
    cycle(0, 0, 0, "runjump_idle");
    for (int i = 0; i < 13; i++) begin
      cycle(0, 1, 0, "arc");
      if (i == 5) expect_eq("arc_peak_t7", int'(height), 7);
      cycle(0, 0, 1, "arc_idle");
    end
    expect_eq("arc_peak", peak, 7);
    expect_eq("arc_xpos", int'(xpos), 32);
    expect_eq("arc_lands", lands, 1);
    expect_eq("arc_jc", int'(jump_count), 1);

    cycle(0, 1, 1, "dive_seq");
    expect_eq("dive_h0", int'(height), hs[0]);
    for (int i = 1; i < 4; i++) begin
      cycle(0, 1, 0, "dive_seq");
      expect_eq("dive_h", int'(height), hs[i]);
    end
    cycle(0, 1, 2, "dive_seq");
    expect_eq("dive_h4", int'(height), hs[4]);
    expect_eq("dive_pose", int'(pose), 2);
    cycle(0, 1, 3, "dive_seq");
    expect_eq("dive_h5", int'(height), hs[5]);
    expect_eq("dive_land", int'(land), 1);
    expect_eq("dive_xpos", int'(xpos), 32);

    cycle(1, 0, 0, "rst2");
    for (int i = 0; i < 40; i++) cycle(0, 1, 1, "hold_jump");
    expect_eq("hold_jump_jc", int'(jump_count), 3);

    cycle(1, 0, 0, "rst3");
    cycle(0, 1, 1, "abort");
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, "abort");
    expect_eq("abort_h5", int'(height), 5);
    cycle(1, 1, 0, "abort_rst");
    expect_eq("abort_land", int'(land), 0);
    cycle(0, 0, 0, "abort_after");
    expect_eq("abort_land2", int'(land), 0);

    for (int i = 0; i < 127; i++) cycle(0, 1, 3, "to254");
    expect_eq("x254", int'(xpos), 254);
    cycle(0, 1, 3, "wrap");
    expect_eq("wrap_x", int'(xpos), 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, i % 4, "hold");

    cycle(1, 0, 0, "rst4");
    cycle(0, 1, 0, "sat_stand");
    for (int i = 0; i < 3700; i++) cycle(0, 1, 1, "sat");
    expect_eq("sat_jc", int'(jump_count), 255);

    for (int i = 0; i < 600; i++)
      cycle(($urandom % 64) == 0, ($urandom % 3) == 0,
            int'($urandom % 4), "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avatar_motion.md
AVATAR_MOTION -- requirements
Module: avatar_motion

Interface
REQ-001 The module SHALL have parameter JUMP_PEAK, default 7, giving the jump apex height (1..15).
REQ-002 The module SHALL have parameter RUN_STEP, default 2, giving the x increment per frame while running or carrying run momentum.
REQ-003 The module SHALL have parameter DIVE_STEP, default 2, giving the height decrement per frame while diving.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 action  input  2  controller command, sampled on frame ticks only: 00 stand, 01 jump, 10 dive/crouch, 11 run.
REQ-007 frame_tick  input  1  single-cycle pulse; motion advances only on cycles where it is high.
REQ-008 xpos  output  8  horizontal position, registered, modulo 256.
REQ-009 height  output  4  vertical position, registered, 0 = ground.
REQ-010 pose  output  2  registered: 00 standing, 01 airborne, 10 crouch/dive, 11 running.
REQ-011 airborne  output  1  high whenever the motion state is not GROUND.
REQ-012 land  output  1  one-clock pulse, registered, asserted in the cycle after the tick that returns height to 0.
REQ-013 jump_count  output  8  saturating count of jump launches.

Function
REQ-014 Motion states SHALL be GROUND, RISE, FALL, DIVE; without frame_tick every register SHALL hold, except land, which clears.
REQ-015 GROUND tick, action 01: RISE, height 1, vx latched to RUN_STEP if run_flag is set else 0, jump_count +1 saturating at 255, xpos unchanged.
REQ-016 GROUND tick, action 11: xpos += RUN_STEP (wraps), run_flag set, pose 11.
REQ-017 GROUND tick, action 00 or 10: run_flag cleared, xpos unchanged, pose 00 or 10 respectively.
REQ-018 RISE tick, action not 10: xpos += vx, height +1; when new height equals JUMP_PEAK, state SHALL become FALL.
REQ-019 FALL tick, action not 10: xpos += vx, height -1; when new height is 0, state GROUND and land pulses.
REQ-020 RISE or FALL tick, action 10: DIVE, height = max(height-DIVE_STEP, 0), xpos unchanged; if the result is 0, go directly to GROUND with land.
REQ-021 DIVE tick: height = max(height-DIVE_STEP, 0), xpos unchanged, action ignored; at 0, GROUND with land.
REQ-022 Airborne actions 00, 01, 11 SHALL not alter the trajectory (no double jump).
REQ-023 On every landing, vx and run_flag SHALL clear and pose SHALL become 00.
REQ-024 pose SHALL be 01 in RISE/FALL and 10 in DIVE.
REQ-025 Height SHALL never underflow or exceed JUMP_PEAK; xpos SHALL wrap 254 + 2 -> 0.

Reset
REQ-026 On reset: state GROUND, xpos 0, height 0, pose 00, airborne 0, land 0, jump_count 0, vx 0, run_flag 0.
REQ-027 Reset SHALL take priority over a coincident frame_tick and SHALL abort any jump or dive immediately, with no land pulse.

Structure
REQ-028 Package avatar_pkg SHALL hold the action_t enum (same 2-bit encoding as the controller output) and the motion_state_t enum.
REQ-029 The block SHALL be one module with no sub-module: one always_ff for state/datapath and one always_comb for next-state.

Verification
REQ-030 Reset, then 3 ticks of action 11 -> xpos 6, pose 11, height 0.
REQ-031 From REQ-030, 1 tick action 01, then 13 ticks of action 00 -> height peaks at 7 on the 7th tick overall, xpos 32, land pulses once, jump_count 1.
REQ-032 Standing jump, then 3 ticks of action 00, then 1 tick action 10 -> height 1,2,3,4, then 2 in DIVE, then 0 on the next tick with land, xpos unchanged.
REQ-033 Action 01 held on every tick for 40 ticks -> each landing is followed by a relaunch, no mid-air relaunch, jump_count 3.
REQ-034 Reset asserted with frame_tick at height 5 -> all outputs return to reset values next cycle, no land pulse.
REQ-035 Start at xpos 254, 1 run tick -> xpos 0; frame_tick held low for 10 cycles -> all outputs unchanged.
